loot_bank: RTL and testbench

LOOT_BANK -- requirements
Module: loot_bank

---
 rtl/game_pkg.sv | 35 +++
 rtl/loot_wallet.sv | 152 +++++++++++++++
 rtl/loot_bank.sv | 111 +++++++++++
 tb/tb_loot_bank.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
//============================================================================
// Module      : game_pkg
// Description : Shared types and widths for the loot bank game logic.
//               The player-state enum gains ST_STUNNED only when the
//               LOOT_BANK_STUN_EN macro is defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package game_pkg;

    // Register widths for carried and banked money
    localparam int c_CARRY_W  = 4;
    localparam int c_SCORE_W  = 8;
    localparam int c_WINNER_W = 2;

    // Winner output encodings
    localparam logic [c_WINNER_W-1:0] c_WIN_NONE = 2'b00;
    localparam logic [c_WINNER_W-1:0] c_WIN_P1   = 2'b01;
    localparam logic [c_WINNER_W-1:0] c_WIN_P2   = 2'b10;

    // Per-player state machine states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CARRYING   = 2'd1,
        ST_DEPOSITING = 2'd2
`ifdef LOOT_BANK_STUN_EN
        ,
        ST_STUNNED    = 2'd3
`endif
    } player_state_t;

endpackage : game_pkg

`default_nettype wire

// File: rtl/loot_wallet.sv
//============================================================================
// Module      : loot_wallet
// Description : One player's money handling: collect edge detection,
//               saturating carry, vault deposit one unit per frame, hit
//               handling and (with LOOT_BANK_STUN_EN) a stun cooldown.
//               Exposes the next-score value so the top can arbitrate the
//               win on the same edge the score changes.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module loot_wallet
    import game_pkg::*;
#(
    parameter int CARRY_MAX   = 4
`ifdef LOOT_BANK_STUN_EN
    ,
    parameter int STUN_FRAMES = 60
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_run,
    input  logic [1:0]           i_collect,
    input  logic                 i_in_vault,
    input  logic                 i_hit,
    output logic [c_CARRY_W-1:0] o_carry,
    output logic [c_SCORE_W-1:0] o_score,
    output logic [c_SCORE_W-1:0] o_score_nxt,
    output logic                 o_full
);

    localparam logic [c_CARRY_W-1:0] c_CARRY_LIMIT = c_CARRY_W'(CARRY_MAX);
    localparam logic [c_CARRY_W:0]   c_SUM_LIMIT   = (c_CARRY_W + 1)'(CARRY_MAX);

    player_state_t          r_state;
    player_state_t          w_state_nxt;
    logic [c_CARRY_W-1:0]   r_carry;
    logic [c_CARRY_W-1:0]   w_carry_nxt;
    logic [c_SCORE_W-1:0]   r_score;
    logic [c_SCORE_W-1:0]   w_score_nxt;
    logic                   r_prev_nz;
    logic                   w_collect_edge;
    logic [c_CARRY_W:0]     w_carry_sum;
    logic [c_CARRY_W-1:0]   w_carry_add;

`ifdef LOOT_BANK_STUN_EN
    localparam int                 c_STUN_W    = $clog2(STUN_FRAMES + 1);
    localparam logic [c_STUN_W-1:0] c_STUN_LOAD = c_STUN_W'(STUN_FRAMES);

    logic [c_STUN_W-1:0] r_stun;
    logic [c_STUN_W-1:0] w_stun_nxt;
`endif

    // A collect counts only on the frame its value turns nonzero
    assign w_collect_edge = (i_collect != 2'b00) && !r_prev_nz;

    // Carry plus new money, clipped at the carry limit (excess is lost)
    assign w_carry_sum = {1'b0, r_carry} + {{(c_CARRY_W - 1){1'b0}}, i_collect};
    assign w_carry_add = (w_carry_sum > c_SUM_LIMIT) ? c_CARRY_LIMIT
                                                     : w_carry_sum[c_CARRY_W-1:0];

    // Next-state logic; priority is hit, then deposit, then collect
    always_comb begin
        w_state_nxt = r_state;
        w_carry_nxt = r_carry;
        w_score_nxt = r_score;
`ifdef LOOT_BANK_STUN_EN
        w_stun_nxt  = r_stun;
`endif
        if (i_hit) begin
            w_carry_nxt = '0;
`ifdef LOOT_BANK_STUN_EN
            w_state_nxt = ST_STUNNED;
            w_stun_nxt  = c_STUN_LOAD;
`else
            w_state_nxt = ST_IDLE;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_collect_edge) begin
                        w_carry_nxt = w_carry_add;
                        w_state_nxt = ST_CARRYING;
                    end
                end
                ST_CARRYING: begin
                    if (i_in_vault) begin
                        w_state_nxt = ST_DEPOSITING;
                    end else if (w_collect_edge) begin
                        w_carry_nxt = w_carry_add;
                    end
                end
                ST_DEPOSITING: begin
                    if (i_in_vault) begin
                        w_carry_nxt = r_carry - c_CARRY_W'(1);
                        if (r_score != '1) begin
                            w_score_nxt = r_score + c_SCORE_W'(1);
                        end
                        if (r_carry == c_CARRY_W'(1)) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_CARRYING;
                    end
                end
`ifdef LOOT_BANK_STUN_EN
                ST_STUNNED: begin
                    if (r_stun <= c_STUN_W'(1)) begin
                        w_stun_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stun_nxt  = r_stun - c_STUN_W'(1);
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State registers advance only while the round is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_carry   <= '0;
            r_score   <= '0;
            r_prev_nz <= 1'b0;
`ifdef LOOT_BANK_STUN_EN
            r_stun    <= '0;
`endif
        end else if (i_run) begin
            r_state   <= w_state_nxt;
            r_carry   <= w_carry_nxt;
            r_score   <= w_score_nxt;
            r_prev_nz <= (i_collect != 2'b00);
`ifdef LOOT_BANK_STUN_EN
            r_stun    <= w_stun_nxt;
`endif
        end
    end

    assign o_carry     = r_carry;
    assign o_score     = r_score;
    assign o_full      = (r_carry == c_CARRY_LIMIT);
    assign o_score_nxt = i_run ? w_score_nxt : r_score;

endmodule : loot_wallet

`default_nettype wire

// File: rtl/loot_bank.sv
//============================================================================
// Module      : loot_bank
// Description : Two-player loot banking. Each player has a loot_wallet; this
//               level decides the round winner and freezes play once the
//               round is over. Optional stun cooldown: LOOT_BANK_STUN_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module loot_bank
    import game_pkg::*;
#(
    parameter int CARRY_MAX   = 4,
    parameter int WIN_SCORE   = 20,
    parameter int STUN_FRAMES = 60
) (
    input  logic                  FrameClk,
    input  logic                  ResetN,
    input  logic                  GameEnable,
    input  logic [1:0]            P1Collect,
    input  logic [1:0]            P2Collect,
    input  logic                  P1InVault,
    input  logic                  P2InVault,
    input  logic                  P1Hit,
    input  logic                  P2Hit,
    output logic                  P1Full,
    output logic                  P2Full,
    output logic [c_CARRY_W-1:0]  P1Carry,
    output logic [c_CARRY_W-1:0]  P2Carry,
    output logic [c_SCORE_W-1:0]  P1Score,
    output logic [c_SCORE_W-1:0]  P2Score,
    output logic [c_WINNER_W-1:0] Winner,
    output logic                  GameOver
);

    localparam logic [c_SCORE_W-1:0] c_WIN_LEVEL = c_SCORE_W'(WIN_SCORE);

    // Reject parameter values the carry/stun registers cannot represent
    if (CARRY_MAX < 1 || CARRY_MAX > 15 || STUN_FRAMES < 1) begin : g_param_check
        $error("loot_bank: CARRY_MAX or STUN_FRAMES out of range");
    end

    logic                  r_game_over;
    logic [c_WINNER_W-1:0] r_winner;
    logic                  w_run;
    logic [c_SCORE_W-1:0]  w_p1_score_nxt;
    logic [c_SCORE_W-1:0]  w_p2_score_nxt;

    // Play advances only while enabled and the round is undecided
    assign w_run = GameEnable && !r_game_over;

    loot_wallet #(
        .CARRY_MAX   (CARRY_MAX)
`ifdef LOOT_BANK_STUN_EN
        ,
        .STUN_FRAMES (STUN_FRAMES)
`endif
    ) u_wallet_p1 (
        .clk         (FrameClk),
        .rst_n       (ResetN),
        .i_run       (w_run),
        .i_collect   (P1Collect),
        .i_in_vault  (P1InVault),
        .i_hit       (P1Hit),
        .o_carry     (P1Carry),
        .o_score     (P1Score),
        .o_score_nxt (w_p1_score_nxt),
        .o_full      (P1Full)
    );

    loot_wallet #(
        .CARRY_MAX   (CARRY_MAX)
`ifdef LOOT_BANK_STUN_EN
        ,
        .STUN_FRAMES (STUN_FRAMES)
`endif
    ) u_wallet_p2 (
        .clk         (FrameClk),
        .rst_n       (ResetN),
        .i_run       (w_run),
        .i_collect   (P2Collect),
        .i_in_vault  (P2InVault),
        .i_hit       (P2Hit),
        .o_carry     (P2Carry),
        .o_score     (P2Score),
        .o_score_nxt (w_p2_score_nxt),
        .o_full      (P2Full)
    );

    // Latch the winner on the edge a score first reaches the target; P1 wins ties
    always_ff @(posedge FrameClk or negedge ResetN) begin
        if (!ResetN) begin
            r_game_over <= 1'b0;
            r_winner    <= c_WIN_NONE;
        end else if (w_run) begin
            if (w_p1_score_nxt >= c_WIN_LEVEL) begin
                r_game_over <= 1'b1;
                r_winner    <= c_WIN_P1;
            end else if (w_p2_score_nxt >= c_WIN_LEVEL) begin
                r_game_over <= 1'b1;
                r_winner    <= c_WIN_P2;
            end
        end
    end

    assign GameOver = r_game_over;
    assign Winner   = r_winner;

endmodule : loot_bank

`default_nettype wire

// File: tb/tb_loot_bank.sv
//============================================================================
// Module      : tb_loot_bank
// Description : Self-checking bench for loot_bank: directed scenarios plus
//               randomized play against a behavioural player model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_loot_bank;

    localparam int CARRY_MAX   = 4;
    localparam int WIN_SCORE   = 20;
    localparam int STUN_FRAMES = 60;

    logic       FrameClk   = 1'b0;
    logic       ResetN     = 1'b1;
    logic       GameEnable = 1'b0;
    logic [1:0] P1Collect  = 2'd0;
    logic [1:0] P2Collect  = 2'd0;
    logic       P1InVault  = 1'b0;
    logic       P2InVault  = 1'b0;
    logic       P1Hit      = 1'b0;
    logic       P2Hit      = 1'b0;
    logic       P1Full, P2Full;
    logic [3:0] P1Carry, P2Carry;
    logic [7:0] P1Score, P2Score;
    logic [1:0] Winner;
    logic       GameOver;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: money held, money banked, in-vault flag,
    // remaining stun frames, last-frame collect nonzero, round result
    int m_carry[2];
    int m_score[2];
    bit m_dep[2];
    int m_stun[2];
    bit m_prevnz[2];
    int m_winner;
    bit m_over;

    loot_bank #(
        .CARRY_MAX   (CARRY_MAX),
        .WIN_SCORE   (WIN_SCORE),
        .STUN_FRAMES (STUN_FRAMES)
    ) dut (
        .FrameClk   (FrameClk),
        .ResetN     (ResetN),
        .GameEnable (GameEnable),
        .P1Collect  (P1Collect),
        .P2Collect  (P2Collect),
        .P1InVault  (P1InVault),
        .P2InVault  (P2InVault),
        .P1Hit      (P1Hit),
        .P2Hit      (P2Hit),
        .P1Full     (P1Full),
        .P2Full     (P2Full),
        .P1Carry    (P1Carry),
        .P2Carry    (P2Carry),
        .P1Score    (P1Score),
        .P2Score    (P2Score),
        .Winner     (Winner),
        .GameOver   (GameOver)
    );

    always #5 FrameClk = ~FrameClk;

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            m_carry[p]  = 0;
            m_score[p]  = 0;
            m_dep[p]    = 1'b0;
            m_stun[p]   = 0;
            m_prevnz[p] = 1'b0;
        end
        m_winner = 0;
        m_over   = 1'b0;
    endtask

    // One frame of the game rules applied to the current inputs
    task automatic m_step();
        int c[2];
        bit v[2];
        bit h[2];
        bit edge_seen;
        c[0] = int'(P1Collect); c[1] = int'(P2Collect);
        v[0] = P1InVault;       v[1] = P2InVault;
        h[0] = P1Hit;           h[1] = P2Hit;
        if (!GameEnable || m_over) return;
        for (int p = 0; p < 2; p++) begin
            edge_seen   = (c[p] != 0) && !m_prevnz[p];
            m_prevnz[p] = (c[p] != 0);
            if (h[p]) begin
                m_carry[p] = 0;
                m_dep[p]   = 1'b0;
`ifdef LOOT_BANK_STUN_EN
                m_stun[p]  = STUN_FRAMES;
`endif
            end else if (m_stun[p] > 0) begin
                m_stun[p] = m_stun[p] - 1;
            end else if (m_dep[p]) begin
                if (v[p]) begin
                    m_carry[p] = m_carry[p] - 1;
                    if (m_score[p] < 255) m_score[p] = m_score[p] + 1;
                    if (m_carry[p] == 0) m_dep[p] = 1'b0;
                end else begin
                    m_dep[p] = 1'b0;
                end
            end else if (m_carry[p] > 0 && v[p]) begin
                m_dep[p] = 1'b1;
            end else if (edge_seen) begin
                m_carry[p] = m_carry[p] + c[p];
                if (m_carry[p] > CARRY_MAX) m_carry[p] = CARRY_MAX;
            end
        end
        if (m_score[0] >= WIN_SCORE) begin
            m_over = 1'b1; m_winner = 1;
        end else if (m_score[1] >= WIN_SCORE) begin
            m_over = 1'b1; m_winner = 2;
        end
    endtask

    function automatic logic [28:0] dut_vec();
        return {P1Full, P2Full, P1Carry, P2Carry, P1Score, P2Score, Winner, GameOver};
    endfunction

    function automatic logic [28:0] model_vec();
        return {(m_carry[0] == CARRY_MAX), (m_carry[1] == CARRY_MAX),
                4'(m_carry[0]), 4'(m_carry[1]), 8'(m_score[0]), 8'(m_score[1]),
                2'(m_winner), m_over};
    endfunction

    // Advance one frame: inputs stay put across the edge, outputs settle by +1
    task automatic step();
        @(posedge FrameClk);
        #1;
        m_step();
    endtask

    task automatic idle_inputs();
        P1Collect = 2'd0; P2Collect = 2'd0;
        P1InVault = 1'b0; P2InVault = 1'b0;
        P1Hit     = 1'b0; P2Hit     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        ResetN = 1'b0;
        #4;
        m_reset();
        ResetN     = 1'b1;
        GameEnable = 1'b1;
    endtask

    // Collect `units` one-unit pulses then bank them, both players together
    task automatic bank_both(input int units);
        for (int u = 0; u < units; u++) begin
            P1Collect = 2'd1; P2Collect = 2'd1; step();
            P1Collect = 2'd0; P2Collect = 2'd0; step();
        end
        P1InVault = 1'b1; P2InVault = 1'b1;
        for (int f = 0; f <= units; f++) step();
        P1InVault = 1'b0; P2InVault = 1'b0;
        step();
    endtask

    task automatic test_reset();
        P1Collect = 2'd3; P2Hit = 1'b1; GameEnable = 1'b1;
        #1;
        ResetN = 1'b0;
        #2;
        checks++;
        if (dut_vec() !== 29'd0) begin
            errors++;
            $display("FAIL reset_async: outputs %h want 0", dut_vec());
        end
        #10;
        apply_reset();
        step();
        checks++;
        if (dut_vec() !== 29'd0) begin
            errors++;
            $display("FAIL reset_idle_frame: outputs %h want 0", dut_vec());
        end
    endtask

    task automatic test_collect_edge();
        int seq[5] = '{0, 2, 2, 2, 0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            P1Collect = 2'(seq[i]);
            step();
            checks++;
            if (P1Carry !== ((i == 0) ? 4'd0 : 4'd2)) begin
                errors++;
                $display("FAIL collect_edge frame %0d: P1Carry %0d want %0d",
                         i, P1Carry, (i == 0) ? 0 : 2);
            end
        end
    endtask

    task automatic test_saturate();
        int seq[6] = '{2, 0, 2, 0, 1, 0};
        int exp[6] = '{2, 2, 4, 4, 4, 4};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            P1Collect = 2'(seq[i]);
            step();
            checks++;
            if (P1Carry !== 4'(exp[i])) begin
                errors++;
                $display("FAIL saturate frame %0d: P1Carry %0d want %0d", i, P1Carry, exp[i]);
            end
        end
        checks++;
        if (P1Full !== 1'b1) begin
            errors++;
            $display("FAIL saturate_full: P1Full %0b want 1", P1Full);
        end
    endtask

    task automatic test_deposit();
        int exp_s[5] = '{0, 1, 2, 3, 3};
        int exp_c[5] = '{3, 2, 1, 0, 0};
        apply_reset();
        P1Collect = 2'd2; step();
        P1Collect = 2'd0; step();
        P1Collect = 2'd1; step();
        P1Collect = 2'd0; step();
        P1InVault = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (P1Score !== 8'(exp_s[i]) || P1Carry !== 4'(exp_c[i])) begin
                errors++;
                $display("FAIL deposit frame %0d: score %0d carry %0d want score %0d carry %0d",
                         i, P1Score, P1Carry, exp_s[i], exp_c[i]);
            end
        end
        P1InVault = 1'b0;
        P1Collect = 2'd1;
        step();
        checks++;
        if (P1Carry !== 4'd1 || P1Score !== 8'd3) begin
            errors++;
            $display("FAIL deposit_then_collect: carry %0d score %0d want carry 1 score 3",
                     P1Carry, P1Score);
        end
    endtask

    task automatic test_hit();
        apply_reset();
        P2Collect = 2'd2; step();
        P2Collect = 2'd0; step();
        P2Collect = 2'd2; step();
        P2Collect = 2'd0; step();
        P2InVault = 1'b1; P2Hit = 1'b1;
        step();
        P2InVault = 1'b0; P2Hit = 1'b0;
        checks++;
        if (P2Carry !== 4'd0 || P2Score !== 8'd0 || P2Full !== 1'b0) begin
            errors++;
            $display("FAIL hit_clear: carry %0d score %0d full %0b want 0 0 0",
                     P2Carry, P2Score, P2Full);
        end
`ifdef LOOT_BANK_STUN_EN
        for (int k = 1; k <= STUN_FRAMES; k++) begin
            P2Collect = (k % 2 == 1) ? 2'd1 : 2'd0;
            step();
            checks++;
            if (P2Carry !== 4'd0) begin
                errors++;
                $display("FAIL stun_ignore frame %0d: P2Carry %0d want 0", k, P2Carry);
            end
        end
`endif
        P2Collect = 2'd1;
        step();
        checks++;
        if (P2Carry !== 4'd1) begin
            errors++;
            $display("FAIL after_hit_collect: P2Carry %0d want 1", P2Carry);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        for (int r = 0; r < 4; r++) bank_both(4);
        bank_both(3);
        checks++;
        if (P1Score !== 8'd19 || P2Score !== 8'd19 || GameOver !== 1'b0) begin
            errors++;
            $display("FAIL tie_setup: scores %0d %0d over %0b want 19 19 0",
                     P1Score, P2Score, GameOver);
        end
        P1Collect = 2'd1; P2Collect = 2'd1; step();
        P1Collect = 2'd0; P2Collect = 2'd0;
        P1InVault = 1'b1; P2InVault = 1'b1;
        step();
        step();
        checks++;
        if (GameOver !== 1'b1 || Winner !== 2'b01 || P1Score !== 8'd20 || P2Score !== 8'd20) begin
            errors++;
            $display("FAIL tie_win: over %0b winner %b scores %0d %0d want 1 01 20 20",
                     GameOver, Winner, P1Score, P2Score);
        end
        for (int i = 0; i < 20; i++) begin
            P1Collect = 2'($urandom_range(0, 3)); P2Collect = 2'($urandom_range(0, 3));
            P1InVault = 1'($urandom); P2InVault = 1'($urandom);
            P1Hit     = 1'($urandom); P2Hit     = 1'($urandom);
            step();
        end
        checks++;
        if (dut_vec() !== {1'b0, 1'b0, 4'd0, 4'd0, 8'd20, 8'd20, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL tie_frozen: outputs %h want frozen at 20/20 winner 01", dut_vec());
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_deposit();
        apply_reset();
        for (int u = 0; u < 3; u++) begin
            P1Collect = 2'd1; step();
            P1Collect = 2'd0; step();
        end
        P1InVault = 1'b1;
        step();
        step();
        checks++;
        if (P1Score !== 8'd1 || P1Carry !== 4'd2) begin
            errors++;
            $display("FAIL middep_setup: score %0d carry %0d want 1 2", P1Score, P1Carry);
        end
        #2;
        ResetN = 1'b0;
        #2;
        checks++;
        if (dut_vec() !== 29'd0) begin
            errors++;
            $display("FAIL middep_async: outputs %h want 0", dut_vec());
        end
        ResetN = 1'b1;
        m_reset();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (P1Score !== 8'd0 || P1Carry !== 4'd0) begin
            errors++;
            $display("FAIL middep_discard: score %0d carry %0d want 0 0", P1Score, P1Carry);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 3; ep++) begin
            apply_reset();
            for (int i = 0; i < 300; i++) begin
                GameEnable = ($urandom_range(0, 9) != 0);
                P1Collect  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
                P2Collect  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
                P1InVault  = ($urandom_range(0, 9) < 4);
                P2InVault  = ($urandom_range(0, 9) < 4);
                P1Hit      = ($urandom_range(0, 99) < 3);
                P2Hit      = ($urandom_range(0, 99) < 3);
                step();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL random ep %0d frame %0d: outputs %h want %h",
                             ep, i, dut_vec(), model_vec());
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_collect_edge();
        test_saturate();
        test_deposit();
        test_hit();
        test_tie();
        test_reset_mid_deposit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_loot_bank

`default_nettype wire
